// File: rtl/local_history_predictor_pkg.sv
// Shared constants, counter type and saturating-counter helpers for the
// local history branch predictor.
package local_pred_pkg;

  localparam int DEF_PC_WIDTH    = 10;
  localparam int DEF_INDEX_WIDTH = 4;
  localparam int DEF_HIST_WIDTH  = 3;
  localparam int DEF_CTR_WIDTH   = 2;

  // Widest counter the helpers below can handle.
  localparam int MAX_CTR_WIDTH   = 8;

  typedef logic [DEF_CTR_WIDTH-1:0] ctr_t;
  typedef logic [MAX_CTR_WIDTH-1:0] wide_ctr_t;

  // Weakly-not-taken: the largest value whose MSB is still 0.
  localparam ctr_t WEAK_NT = ctr_t'((32'd1 << (DEF_CTR_WIDTH - 1)) - 32'd1);

  // Weakly-not-taken value for an arbitrary counter width.
  function automatic wide_ctr_t weak_nt_of(input int width);
    return wide_ctr_t'((32'd1 << (width - 1)) - 32'd1);
  endfunction

  // One saturating step (up when 'up' is set) for a counter 'width' bits wide.
  function automatic wide_ctr_t sat_step(input wide_ctr_t value, input logic up,
                                         input int width);
    wide_ctr_t max_v;
    wide_ctr_t res;
    max_v = wide_ctr_t'((32'd1 << width) - 32'd1);
    if (up) begin
      if (value >= max_v) res = max_v;
      else                res = value + 8'd1;
    end else begin
      if (value == 8'd0)  res = 8'd0;
      else                res = value - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/local_history_predictor_entry.sv
// pred_entry: one predictor entry -- a local history shift register plus
// 2^HIST_WIDTH saturating counters. Clear has priority over update.
// Read ports expose the counter selected by the entry's own history (for
// lookups) and the counter selected by upd_hist (pre-update value).
module pred_entry
  import local_pred_pkg::*;
#(
  parameter int HIST_WIDTH = DEF_HIST_WIDTH,
  parameter int CTR_WIDTH  = DEF_CTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  upd_en,
  input  logic [HIST_WIDTH-1:0] upd_hist,
  input  logic                  upd_taken,
  output logic [HIST_WIDTH-1:0] hist,
  output logic [CTR_WIDTH-1:0]  hist_ctr,
  output logic [CTR_WIDTH-1:0]  upd_ctr
);

  localparam int NUM_CTRS = 2 ** HIST_WIDTH;
  localparam logic [CTR_WIDTH-1:0] INIT_CTR = CTR_WIDTH'(weak_nt_of(CTR_WIDTH));

  logic [HIST_WIDTH-1:0] hist_r;
  logic [HIST_WIDTH-1:0] hist_next_s;
  logic [CTR_WIDTH-1:0]  ctr_r [NUM_CTRS];
  logic [CTR_WIDTH-1:0]  ctr_next_s;

  // Next history (shift in outcome) and next value of the addressed counter.
  always_comb begin
    hist_next_s    = hist_r << 1;
    hist_next_s[0] = upd_taken;
    ctr_next_s     = CTR_WIDTH'(sat_step(wide_ctr_t'(ctr_r[upd_hist]), upd_taken, CTR_WIDTH));
  end

  // Entry state: reset/clear to history 0 and weakly-not-taken counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= '0;
      for (int i = 0; i < NUM_CTRS; i++) ctr_r[i] <= INIT_CTR;
    end else if (clear) begin
      hist_r <= '0;
      for (int i = 0; i < NUM_CTRS; i++) ctr_r[i] <= INIT_CTR;
    end else if (upd_en) begin
      hist_r          <= hist_next_s;
      ctr_r[upd_hist] <= ctr_next_s;
    end else begin
      hist_r <= hist_r;
    end
  end

  assign hist     = hist_r;
  assign hist_ctr = ctr_r[hist_r];
  assign upd_ctr  = ctr_r[upd_hist];

endmodule

// File: rtl/local_history_predictor.sv
// local_history_predictor: PC-indexed table of local histories, each history
// selecting a saturating counter within its entry. Lookups are registered and
// see pre-update/pre-evict state. Evict beats an update to the same entry.
// Optional feature macro: LOCAL_PRED_STATS_EN adds stat_updates and
// stat_mispredicts counters.
module local_history_predictor
  import local_pred_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int HIST_WIDTH  = DEF_HIST_WIDTH,
  parameter int CTR_WIDTH   = DEF_CTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [HIST_WIDTH-1:0] pred_hist,
  input  logic                  update_valid,
  input  logic [PC_WIDTH-1:0]   update_pc,
  input  logic [HIST_WIDTH-1:0] update_hist,
  input  logic                  update_taken,
  input  logic                  evict,
  input  logic [PC_WIDTH-1:0]   evict_pc
`ifdef LOCAL_PRED_STATS_EN
  ,
  output logic [15:0]           stat_updates,
  output logic [15:0]           stat_mispredicts
`endif
);

  localparam int NUM_ENTRIES = 2 ** INDEX_WIDTH;

  logic [INDEX_WIDTH-1:0] lookup_idx_s;
  logic [INDEX_WIDTH-1:0] update_idx_s;
  logic [INDEX_WIDTH-1:0] evict_idx_s;
  logic [NUM_ENTRIES-1:0] clear_s;
  logic [NUM_ENTRIES-1:0] upd_en_s;
  logic [HIST_WIDTH-1:0]  ent_hist_s     [NUM_ENTRIES];
  logic [CTR_WIDTH-1:0]   ent_hist_ctr_s [NUM_ENTRIES];
  logic [CTR_WIDTH-1:0]   ent_upd_ctr_s  [NUM_ENTRIES];
  logic [HIST_WIDTH-1:0]  look_hist_s;
  logic [CTR_WIDTH-1:0]   look_ctr_s;
  logic [CTR_WIDTH-1:0]   upd_ctr_s;

  // Only the low PC bits select an entry; aliasing PCs share it.
  assign lookup_idx_s = lookup_pc[INDEX_WIDTH-1:0];
  assign update_idx_s = update_pc[INDEX_WIDTH-1:0];
  assign evict_idx_s  = evict_pc[INDEX_WIDTH-1:0];

  // Per-entry clear and update enables; an evict suppresses an update to the same entry.
  always_comb begin
    clear_s  = '0;
    upd_en_s = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      clear_s[e]  = evict && (evict_idx_s == INDEX_WIDTH'(e));
      upd_en_s[e] = update_valid && (update_idx_s == INDEX_WIDTH'(e)) && !clear_s[e];
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    pred_entry #(
      .HIST_WIDTH (HIST_WIDTH),
      .CTR_WIDTH  (CTR_WIDTH)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s[g]),
      .upd_en    (upd_en_s[g]),
      .upd_hist  (update_hist),
      .upd_taken (update_taken),
      .hist      (ent_hist_s[g]),
      .hist_ctr  (ent_hist_ctr_s[g]),
      .upd_ctr   (ent_upd_ctr_s[g])
    );
  end

  // Select the looked-up entry's history/counter and the updated entry's counter.
  always_comb begin
    look_hist_s = ent_hist_s[lookup_idx_s];
    look_ctr_s  = ent_hist_ctr_s[lookup_idx_s];
    upd_ctr_s   = ent_upd_ctr_s[update_idx_s];
  end

  // Registered prediction; direction and history hold when no lookup is made.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_hist  <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= look_ctr_s[CTR_WIDTH-1];
        pred_hist  <= look_hist_s;
      end else begin
        pred_taken <= pred_taken;
        pred_hist  <= pred_hist;
      end
    end
  end

`ifdef LOCAL_PRED_STATS_EN
  logic upd_applied_s;
  logic unused_pc_s;

  assign upd_applied_s = update_valid && !(evict && (evict_idx_s == update_idx_s));
  assign unused_pc_s   = ^{lookup_pc[PC_WIDTH-1:INDEX_WIDTH], update_pc[PC_WIDTH-1:INDEX_WIDTH],
                           evict_pc[PC_WIDTH-1:INDEX_WIDTH]};

  // Saturating statistics: all updates, and applied updates the counter got wrong.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= 16'd0;
      stat_mispredicts <= 16'd0;
    end else begin
      if (update_valid && (stat_updates != 16'hFFFF)) stat_updates <= stat_updates + 16'd1;
      else                                            stat_updates <= stat_updates;
      if (upd_applied_s && (upd_ctr_s[CTR_WIDTH-1] != update_taken) &&
          (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
      else
        stat_mispredicts <= stat_mispredicts;
    end
  end
`else
  logic unused_pc_s;

  // Upper PC bits and the update-side counter read are intentionally unused here.
  assign unused_pc_s = ^{lookup_pc[PC_WIDTH-1:INDEX_WIDTH], update_pc[PC_WIDTH-1:INDEX_WIDTH],
                         evict_pc[PC_WIDTH-1:INDEX_WIDTH], upd_ctr_s};
`endif

endmodule

// File: tb/tb_local_history_predictor.sv
// Self-checking bench for local_history_predictor (default parameters).
// Expected predictions come from a behavioural table model and are queued
// when the lookup is driven; observed predictions are queued when pred_valid
// is seen, and each scenario task compares the two queues.
module tb_local_history_predictor;

  logic       clk = 1'b0;
  logic       rst;
  logic       lookup_valid;
  logic [9:0] lookup_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [2:0] pred_hist;
  logic       update_valid;
  logic [9:0] update_pc;
  logic [2:0] update_hist;
  logic       update_taken;
  logic       evict;
  logic [9:0] evict_pc;
`ifdef LOCAL_PRED_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;
`endif

  local_history_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_hist    (pred_hist),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_hist  (update_hist),
    .update_taken (update_taken),
    .evict        (evict),
    .evict_pc     (evict_pc)
`ifdef LOCAL_PRED_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] hist;
    logic       taken;
  } pred_t;

  int    checks = 0;
  int    fails  = 0;
  int    m_hist [16];
  int    m_ctr  [16][8];
  pred_t exp_q [$];
  pred_t obs_q [$];
  logic  last_valid;

  task automatic model_reset();
    for (int e = 0; e < 16; e++) begin
      m_hist[e] = 0;
      for (int h = 0; h < 8; h++) m_ctr[e][h] = 1;
    end
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0; lookup_pc = 10'd0;
    update_valid = 1'b0; update_pc = 10'd0; update_hist = 3'd0; update_taken = 1'b0;
    evict = 1'b0; evict_pc = 10'd0;
  endtask

  // One clock of stimulus; model advanced at the edge, output captured 1ns later.
  task automatic cycle(input bit lv, input logic [9:0] lpc, input bit uv, input logic [9:0] upc,
                       input logic [2:0] uh, input bit ut, input bit ev, input logic [9:0] epc);
    int li, ui, ei;
    pred_t p;
    @(negedge clk);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_hist = uh; update_taken = ut;
    evict = ev; evict_pc = epc;
    @(posedge clk);
    li = int'(lpc[3:0]); ui = int'(upc[3:0]); ei = int'(epc[3:0]);
    if (lv) begin
      p.hist  = m_hist[li][2:0];
      p.taken = (m_ctr[li][m_hist[li]] >= 2);
      exp_q.push_back(p);
    end
    if (ev) begin
      m_hist[ei] = 0;
      for (int h = 0; h < 8; h++) m_ctr[ei][h] = 1;
    end
    if (uv && !(ev && (ei == ui))) begin
      if (ut) begin
        if (m_ctr[ui][uh] < 3) m_ctr[ui][uh] = m_ctr[ui][uh] + 1;
      end else begin
        if (m_ctr[ui][uh] > 0) m_ctr[ui][uh] = m_ctr[ui][uh] - 1;
      end
      m_hist[ui] = ((m_hist[ui] << 1) | int'(ut)) & 7;
    end
    #1;
    last_valid = pred_valid;
    if (pred_valid === 1'b1) obs_q.push_back({pred_hist, pred_taken});
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #12;
    checks++; if (pred_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", pred_valid); end
    checks++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
    checks++; if (pred_hist !== 3'b000) begin fails++; $display("FAIL reset_hist: got %b want 000", pred_hist); end
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 10'h000, 0, 10'h000, 3'd0, 0, 0, 10'h000);
    checks++; if (last_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", last_valid); end
  endtask

  task automatic test_first_lookup();
    pred_t e, o;
    cycle(1, 10'h005, 0, 10'h000, 3'd0, 0, 0, 10'h000);
    checks++; if (last_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b want 1", last_valid); end
    checks++; if ({pred_hist, pred_taken} !== 4'b0000) begin fails++; $display("FAIL first_pred: got hist=%b taken=%b want 000/0", pred_hist, pred_taken); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL first_sb: no prediction, want hist=%b taken=%b", e.hist, e.taken); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL first_sb: got hist=%b taken=%b want hist=%b taken=%b", o.hist, o.taken, e.hist, e.taken); end end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL first_extra: %0d unexpected predictions, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_train_alias();
    pred_t e, o;
    cycle(1, 10'h005, 1, 10'h005, 3'b000, 1, 0, 10'h000);   // lookup sees pre-update history
    cycle(0, 10'h000, 1, 10'h005, 3'b000, 1, 0, 10'h000);
    cycle(0, 10'h000, 1, 10'h005, 3'b000, 1, 0, 10'h000);
    cycle(1, 10'h015, 0, 10'h000, 3'b000, 0, 0, 10'h000);   // alias of 0x005
    checks++; if ({pred_hist, pred_taken} !== 4'b1110) begin fails++; $display("FAIL alias_pred: got hist=%b taken=%b want 111/0", pred_hist, pred_taken); end
    cycle(0, 10'h000, 1, 10'h005, 3'b111, 1, 0, 10'h000);
    checks++; if ({last_valid, pred_hist, pred_taken} !== 5'b01110) begin fails++; $display("FAIL hold_pred: got v=%b hist=%b taken=%b want 0/111/0", last_valid, pred_hist, pred_taken); end
    cycle(1, 10'h005, 0, 10'h000, 3'b000, 0, 0, 10'h000);
    checks++; if ({pred_hist, pred_taken} !== 4'b1111) begin fails++; $display("FAIL trained_pred: got hist=%b taken=%b want 111/1", pred_hist, pred_taken); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL train_sb: no prediction, want hist=%b taken=%b", e.hist, e.taken); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL train_sb: got hist=%b taken=%b want hist=%b taken=%b", o.hist, o.taken, e.hist, e.taken); end end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL train_extra: %0d unexpected predictions, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_floor();
    pred_t e, o;
    cycle(1, 10'h003, 1, 10'h003, 3'b000, 0, 0, 10'h000);
    checks++; if (pred_hist !== 3'b000) begin fails++; $display("FAIL floor_same_cycle: got hist=%b want 000", pred_hist); end
    cycle(0, 10'h000, 1, 10'h003, 3'b000, 0, 0, 10'h000);
    cycle(1, 10'h003, 0, 10'h000, 3'b000, 0, 0, 10'h000);
    checks++; if ({pred_hist, pred_taken} !== 4'b0000) begin fails++; $display("FAIL floor_pred: got hist=%b taken=%b want 000/0", pred_hist, pred_taken); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL floor_sb: no prediction, want hist=%b taken=%b", e.hist, e.taken); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL floor_sb: got hist=%b taken=%b want hist=%b taken=%b", o.hist, o.taken, e.hist, e.taken); end end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL floor_extra: %0d unexpected predictions, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_evict();
    pred_t e, o;
    cycle(1, 10'h005, 1, 10'h005, 3'b111, 1, 1, 10'h005);   // lookup sees pre-evict state
    checks++; if ({pred_hist, pred_taken} !== 4'b1111) begin fails++; $display("FAIL evict_pre: got hist=%b taken=%b want 111/1", pred_hist, pred_taken); end
    cycle(1, 10'h005, 0, 10'h000, 3'b000, 0, 0, 10'h000);
    checks++; if ({pred_hist, pred_taken} !== 4'b0000) begin fails++; $display("FAIL evict_wins: got hist=%b taken=%b want 000/0", pred_hist, pred_taken); end
    cycle(0, 10'h000, 1, 10'h006, 3'b000, 1, 1, 10'h005);
    cycle(1, 10'h006, 0, 10'h000, 3'b000, 0, 0, 10'h000);
    checks++; if ({pred_hist, pred_taken} !== 4'b0010) begin fails++; $display("FAIL evict_other: got hist=%b taken=%b want 001/0", pred_hist, pred_taken); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL evict_sb: no prediction, want hist=%b taken=%b", e.hist, e.taken); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL evict_sb: got hist=%b taken=%b want hist=%b taken=%b", o.hist, o.taken, e.hist, e.taken); end end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL evict_extra: %0d unexpected predictions, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    pred_t e, o;
    logic [9:0] lpc, upc, epc;
    for (int n = 0; n < 400; n++) begin
      lpc = {6'($urandom), 2'b0, 2'($urandom)};
      upc = {6'($urandom), 2'b0, 2'($urandom)};
      epc = {6'($urandom), 2'b0, 2'($urandom)};
      cycle(1'($urandom), lpc, ($urandom_range(0, 3) != 0), upc, 3'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), epc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL b2b_sb: no prediction, want hist=%b taken=%b", e.hist, e.taken); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL b2b_sb: got hist=%b taken=%b want hist=%b taken=%b", o.hist, o.taken, e.hist, e.taken); end end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL b2b_extra: %0d unexpected predictions, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_async_reset();
    pred_t e, o;
    cycle(0, 10'h000, 1, 10'h009, 3'b000, 1, 0, 10'h000);
    cycle(1, 10'h009, 0, 10'h000, 3'b000, 0, 0, 10'h000);   // history 001 now visible
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 10'h009;
    update_valid = 1'b1; update_pc = 10'h009; update_hist = 3'b001; update_taken = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if ({pred_valid, pred_taken, pred_hist} !== 5'b00000) begin fails++; $display("FAIL async_reset: got v=%b taken=%b hist=%b want all 0", pred_valid, pred_taken, pred_hist); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete(); obs_q.delete();
    cycle(1, 10'h009, 0, 10'h000, 3'b000, 0, 0, 10'h000);
    checks++; if ({pred_hist, pred_taken} !== 4'b0000) begin fails++; $display("FAIL async_discard: got hist=%b taken=%b want 000/0", pred_hist, pred_taken); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL async_sb: no prediction, want hist=%b taken=%b", e.hist, e.taken); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL async_sb: got hist=%b taken=%b want hist=%b taken=%b", o.hist, o.taken, e.hist, e.taken); end end
    end
    checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL async_extra: %0d unexpected predictions, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_first_lookup();
    test_train_alias();
    test_floor();
    test_evict();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
